// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if
//   Link between the TX scheduler and the transmit side of uart_top.
//   master : scheduler side (drives tx_en / tx_data, watches tx_busy / tx_done)
//   slave  : uart_top side  (receives tx_en / tx_data, reports tx_busy / tx_done)
// Signals
//   tx_en    1-cycle launch strobe for one frame
//   tx_data  byte to send; held stable by the master until the frame ends
//   tx_busy  high while the UART is shifting a frame
//   tx_done  1-cycle pulse when the frame has been fully sent
interface uart_tx_scheduler_if #(
  parameter int DATA_W = 8
);
  logic              tx_en;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;
  logic              tx_done;

  modport master (output tx_en, output tx_data, input tx_busy, input tx_done);
  modport slave  (input tx_en, input tx_data, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART transmitter among NUM_REQ byte requesters with round-robin
//   arbitration. The winner's byte is latched, launched with a single tx_en
//   cycle, and the frame is tracked until tx_done. A watchdog aborts a frame
//   whose tx_done never arrives so a dead UART cannot stall the requesters.
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   req          per-requester request level, held until ack
//   req_data     flattened bytes, requester i at [i*DATA_W +: DATA_W]
//   ack          1-cycle one-hot pulse: requester's byte taken and launched
//   done         1-cycle one-hot pulse: requester's frame completed
//   timeout_err  1-cycle pulse: watchdog aborted the current frame
//   owner        index of the current or last granted requester
//   sched_busy   high whenever the scheduler is not idle
//   uart         master side of the link to uart_top (tx_en/tx_data/tx_busy/tx_done)
module uart_tx_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT_W = 18,
  parameter int TIMEOUT   = 200000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic [NUM_REQ-1:0]           done,
  output logic                         timeout_err,
  output logic [$clog2(NUM_REQ)-1:0]   owner,
  output logic                         sched_busy,
  uart_tx_scheduler_if.master          uart
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e               state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [TIMEOUT_W-1:0] watchdog;
  logic                 tx_en_q;
  logic [DATA_W-1:0]    tx_data_q;
  logic [NUM_REQ-1:0]   ack_q;

  logic [DATA_W-1:0]    req_bytes [NUM_REQ];
  logic [IDX_W-1:0]     winner;
  logic [IDX_W-1:0]     next_ptr;
  logic [NUM_REQ-1:0]   owner_onehot;
  logic                 wd_terminal;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_bytes[i] = req_data[i*DATA_W +: DATA_W];
  end

  // First set request at or after ptr, wrapping. Scanning from the far end
  // lets the last hit (the nearest one to ptr) win.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    int               idx;
    // NOTE: every variable gets a value before any conditional update, so no
    // path leaves it holding a stale value (which would infer a latch).
    win = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (r[cand]) win = cand;
    end
    return win;
  endfunction

  assign winner       = rr_pick(req, rr_ptr);
  assign next_ptr     = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
  assign wd_terminal  = (watchdog == TIMEOUT_W'(TIMEOUT - 1));

  // done / timeout_err are decoded in the very cycle tx_done (or the watchdog
  // terminal count) is seen, so the requester learns of completion without an
  // extra register stage. Both are gated by WAIT_DONE, so a stray tx_done in
  // any other state, or an asynchronous reset, forces them to 0.
  assign done        = (state == WAIT_DONE && uart.tx_done) ? owner_onehot : '0;
  assign timeout_err = (state == WAIT_DONE) && !uart.tx_done && wd_terminal;
  assign sched_busy  = (state != IDLE);

  assign ack          = ack_q;
  assign uart.tx_en   = tx_en_q;
  assign uart.tx_data = tx_data_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement or block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      watchdog  <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      ack_q     <= '0;
    end else begin
      tx_en_q <= 1'b0;
      ack_q   <= '0;
      unique case (state)
        IDLE: begin
          // The tx_busy guard also covers a reset released while uart_top is
          // still shifting a frame launched before the reset.
          if (|req && !uart.tx_busy) begin
            owner     <= winner;
            tx_data_q <= req_bytes[winner];
            tx_en_q   <= 1'b1;
            ack_q     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          watchdog <= '0;
          state    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          watchdog <= watchdog + 1'b1;
          // tx_done and the terminal count in the same cycle both end the
          // frame here; the timeout_err decode already lets tx_done win.
          if (uart.tx_done || wd_terminal) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
//   Directed bench for uart_tx_scheduler with a behavioural uart_top TX stub.
//   Stub modes: NORMAL answers each tx_en with a frame (busy, then tx_done),
//   MUTE never gets busy and never answers, MANUAL copies man_busy/man_done.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int TIMEOUT_W = 18;
  localparam int TIMEOUT   = 100;
  localparam int FRAME     = 6;

  typedef enum int {S_MANUAL, S_NORMAL, S_MUTE} stub_mode_e;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        done;
  logic                      timeout_err;
  logic [1:0]                owner;
  logic                      sched_busy;

  stub_mode_e stub_mode = S_MANUAL;
  logic       man_busy  = 1'b0;
  logic       man_done  = 1'b0;
  int         stub_cnt  = 0;

  int errors = 0;
  int checks = 0;

  uart_tx_scheduler_if #(.DATA_W(DATA_W)) u ();

  uart_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_W(TIMEOUT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .done(done),
    .timeout_err(timeout_err), .owner(owner), .sched_busy(sched_busy), .uart(u)
  );

  always #5 clk = ~clk;

  // UART stub: registered outputs. In NORMAL mode tx_done is high in the
  // cycle FRAME+1 after the tx_en cycle, with tx_busy dropping at that time.
  always @(posedge clk) begin
    case (stub_mode)
      S_NORMAL: begin
        u.tx_done <= 1'b0;
        if (u.tx_en) begin
          u.tx_busy <= 1'b1;
          stub_cnt  <= FRAME;
        end else if (stub_cnt == 1) begin
          u.tx_busy <= 1'b0;
          u.tx_done <= 1'b1;
          stub_cnt  <= 0;
        end else if (stub_cnt != 0) begin
          stub_cnt <= stub_cnt - 1;
        end
      end
      S_MUTE: begin
        u.tx_busy <= 1'b0;
        u.tx_done <= 1'b0;
        stub_cnt  <= 0;
      end
      default: begin
        u.tx_busy <= man_busy;
        u.tx_done <= man_done;
        stub_cnt  <= 0;
      end
    endcase
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_tx_en(input int max_cycles, output int waited, output bit seen);
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < max_cycles) begin
      @(negedge clk);
      waited++;
      if (u.tx_en) seen = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    req = '0;
    while ((sched_busy || u.tx_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sched_busy || u.tx_busy) begin
      errors++;
      $display("FAIL %s_drain: sched_busy=%0b tx_busy=%0b, required both 0", name, sched_busy, u.tx_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; req_data = '0;
    stub_mode = S_MANUAL; man_busy = 1'b0; man_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack, done, timeout_err, owner, sched_busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b done=%b to=%b owner=%0d busy=%b, required all 0",
               ack, done, timeout_err, owner, sched_busy);
    end
    checks++;
    if ({u.tx_en, u.tx_data} !== 9'h000) begin
      errors++;
      $display("FAIL reset_uart: tx_en=%b tx_data=%h, required 0/00", u.tx_en, u.tx_data);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (sched_busy !== 1'b0 || u.tx_en !== 1'b0 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL idle_no_req: busy=%b tx_en=%b ack=%b, required 0/0/0000", sched_busy, u.tx_en, ack);
    end
  endtask

  task automatic test_single();
    int w; bit seen; bit early_done = 1'b0; bit found = 1'b0;
    stub_mode = S_NORMAL;
    do_reset();
    req_data = 32'h33_A5_22_11;
    req      = 4'b0100;
    wait_tx_en(5, w, seen);
    checks++;
    if (!seen || w != 1) begin
      errors++;
      $display("FAIL single_latency: seen=%0b cycles=%0d, required 1/1", seen, w);
    end
    checks++;
    if (u.tx_data !== 8'hA5 || ack !== 4'b0100 || owner !== 2'd2 || sched_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_launch: tx_data=%h ack=%b owner=%0d busy=%b, required a5/0100/2/1",
               u.tx_data, ack, owner, sched_busy);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (u.tx_en !== 1'b0 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL single_pulse_width: tx_en=%b ack=%b, required 0/0000", u.tx_en, ack);
    end
    for (int i = 0; i < 40 && !found; i++) begin
      if (u.tx_done) found = 1'b1;
      else begin
        if (done !== 4'b0000) early_done = 1'b1;
        @(negedge clk);
      end
    end
    checks++;
    if (!found || early_done) begin
      errors++;
      $display("FAIL single_tx_done_wait: found=%0b early_done=%0b, required 1/0", found, early_done);
    end
    checks++;
    if (done !== 4'b0100 || timeout_err !== 1'b0 || u.tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_done: done=%b to=%b tx_data=%h, required 0100/0/a5", done, timeout_err, u.tx_data);
    end
    @(negedge clk);
    checks++;
    if (done !== 4'b0000 || sched_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after_done: done=%b busy=%b, required 0000/0", done, sched_busy);
    end
    drain("single");
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_owner [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] exp_data  [5] = '{8'h55, 8'hAA, 8'h12, 8'hD4, 8'h55};
    int w; bit seen;
    stub_mode = S_NORMAL;
    do_reset();
    req_data = 32'hD4_12_AA_55;
    req      = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_tx_en(40, w, seen);
      checks++;
      if (!seen || owner !== exp_owner[i] || u.tx_data !== exp_data[i] ||
          ack !== (4'b0001 << exp_owner[i])) begin
        errors++;
        $display("FAIL rr_grant%0d: seen=%0b owner=%0d data=%h ack=%b, required %0d/%h",
                 i, seen, owner, u.tx_data, ack, exp_owner[i], exp_data[i]);
      end
      // tx_done comes FRAME+1 cycles after tx_en, relaunch 2 cycles after that.
      if (i > 0) begin
        checks++;
        if (w != FRAME + 3) begin
          errors++;
          $display("FAIL rr_gap%0d: cycles=%0d, required %0d", i, w, FRAME + 3);
        end
      end
    end
    drain("rr");
  endtask

  task automatic test_alternate();
    logic [1:0] exp_owner [4] = '{2'd0, 2'd3, 2'd0, 2'd3};
    int w; bit seen;
    stub_mode = S_NORMAL;
    do_reset();
    req_data = 32'h44_33_22_11;
    req      = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      wait_tx_en(40, w, seen);
      checks++;
      if (!seen || owner !== exp_owner[i]) begin
        errors++;
        $display("FAIL alt_grant%0d: seen=%0b owner=%0d, required %0d", i, seen, owner, exp_owner[i]);
      end
    end
    drain("alt");
  endtask

  task automatic test_timeout();
    int w; bit seen; int first_to = -1; int to_cnt = 0; int next_en = -1;
    bit saw_done = 1'b0; logic [1:0] next_owner = 2'd0;
    stub_mode = S_MUTE;
    do_reset();
    req = 4'b0011;
    wait_tx_en(5, w, seen);
    checks++;
    if (!seen || owner !== 2'd0) begin
      errors++;
      $display("FAIL to_first_grant: seen=%0b owner=%0d, required 1/0", seen, owner);
    end
    for (int c = 1; c <= 110 && next_en < 0; c++) begin
      @(negedge clk);
      if (timeout_err) begin
        to_cnt++;
        if (first_to < 0) first_to = c;
      end
      if (done !== 4'b0000) saw_done = 1'b1;
      if (u.tx_en) begin
        next_en    = c;
        next_owner = owner;
      end
    end
    checks++;
    if (first_to != TIMEOUT || to_cnt != 1) begin
      errors++;
      $display("FAIL to_pulse: first_cycle=%0d count=%0d, required %0d/1", first_to, to_cnt, TIMEOUT);
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL to_no_done: done pulse seen=1, required 0");
    end
    checks++;
    if (next_en != TIMEOUT + 2 || next_owner !== 2'd1) begin
      errors++;
      $display("FAIL to_next_launch: cycle=%0d owner=%0d, required %0d/1", next_en, next_owner, TIMEOUT + 2);
    end
    drain("to");
  endtask

  // tx_done arriving in the same cycle as the watchdog terminal count.
  task automatic test_timeout_tie();
    int w; bit seen;
    stub_mode = S_MANUAL; man_busy = 1'b0; man_done = 1'b0;
    do_reset();
    req = 4'b1000;
    wait_tx_en(5, w, seen);
    req = '0;
    for (int c = 1; c < TIMEOUT; c++) @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    checks++;
    if (!seen || done !== 4'b1000 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tie_done_wins: seen=%0b done=%b to=%b, required 1/1000/0", seen, done, timeout_err);
    end
    @(negedge clk);
    checks++;
    if (sched_busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tie_idle: busy=%b to=%b, required 0/0", sched_busy, timeout_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    int w; bit seen; bit leaked = 1'b0;
    stub_mode = S_MANUAL; man_busy = 1'b0; man_done = 1'b0;
    do_reset();
    req_data = 32'h44_33_22_11;
    req = 4'b0010;
    wait_tx_en(5, w, seen);
    req = '0;
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    checks++;
    if (!seen || done !== 4'b0010) begin
      errors++;
      $display("FAIL mid_prep_done: seen=%0b done=%b, required 1/0010", seen, done);
    end
    @(negedge clk);
    req = 4'b0100;
    wait_tx_en(5, w, seen);
    req = '0;
    man_busy = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (!seen || owner !== 2'd2 || sched_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_frame: seen=%0b owner=%0d busy=%b, required 1/2/1", seen, owner, sched_busy);
    end
    req = 4'b0110;
    rst = 1'b0;
    #1;
    checks++;
    if ({ack, done, timeout_err, owner, sched_busy, u.tx_en, u.tx_data} !== 21'h0) begin
      errors++;
      $display("FAIL mid_async_reset: ack=%b done=%b to=%b owner=%0d busy=%b tx_en=%b data=%h, required all 0",
               ack, done, timeout_err, owner, sched_busy, u.tx_en, u.tx_data);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (u.tx_en || sched_busy) leaked = 1'b1;
    end
    checks++;
    if (leaked) begin
      errors++;
      $display("FAIL mid_busy_guard: launch while tx_busy=1 seen=1, required 0");
    end
    man_busy = 1'b0;
    wait_tx_en(5, w, seen);
    checks++;
    if (!seen || owner !== 2'd1) begin
      errors++;
      $display("FAIL mid_rr_restart: seen=%0b owner=%0d, required 1/1", seen, owner);
    end
    drain("mid");
  endtask

  task automatic test_done_in_idle();
    stub_mode = S_MANUAL; man_busy = 1'b0; man_done = 1'b0;
    do_reset();
    req = '0;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    checks++;
    if (done !== 4'b0000 || sched_busy !== 1'b0 || u.tx_done !== 1'b1) begin
      errors++;
      $display("FAIL idle_done_ignored: done=%b busy=%b stub_done=%b, required 0000/0/1", done, sched_busy, u.tx_done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sched_busy !== 1'b0 || u.tx_en !== 1'b0 || ack !== 4'b0000 || owner !== 2'd0) begin
      errors++;
      $display("FAIL idle_no_change: busy=%b tx_en=%b ack=%b owner=%0d, required 0/0/0000/0",
               sched_busy, u.tx_en, ack, owner);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_alternate();
    test_timeout();
    test_timeout_tie();
    test_reset_mid_frame();
    test_done_in_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

endmodule
